// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: paces conversions of an external SPI ADC (CNV/SCLK/SDO)
// at a fixed sample rate and presents each result as a one-cycle strobed
// word, ready to feed the median filter's in/enable pair directly.
module adc_spi_sampler #(
    parameter int DATA_WIDTH  = 16,
    parameter int SAMPLE_DIV  = 1000,
    parameter int CONV_CYCLES = 70,
    parameter int SCLK_DIV    = 4
) (
    input  logic                  ck100m,
    input  logic                  srst_n,
    input  logic                  run,
    input  logic                  overrun_clr,
    input  logic                  adc_sdo,
    output logic                  adc_cnv,
    output logic                  adc_sclk,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_enable,
    output logic                  busy,
    output logic                  overrun
);

    localparam int PCNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_MAX  = (CONV_CYCLES > SCLK_DIV) ? CONV_CYCLES : SCLK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int HALVES   = 2 * DATA_WIDTH;
    localparam int HALF_W   = $clog2(HALVES);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PCNT_W-1:0]     pcnt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [HALF_W-1:0]     halves;
    logic [HALF_W-1:0]     halves_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  cnv_next;
    logic                  sclk_next;
    logic [DATA_WIDTH-1:0] sample_next;
    logic                  strobe_next;
    logic                  tick;

    // A tick fires whenever run is high and the period counter sits at zero,
    // so the very first cycle with run high starts a conversion.
    assign tick = run && (pcnt == '0);

    // Sample-rate period counter: free-runs and wraps while run is high and
    // is parked at zero otherwise.
    always_ff @(posedge ck100m) begin
        if (!srst_n) begin
            pcnt <= '0;
        end else if (!run) begin
            pcnt <= '0;
        end else if (pcnt == PCNT_W'(SAMPLE_DIV - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // Frame sequencer: next state plus the next values of every registered
    // output, so adc_cnv/adc_sclk/sample_enable come straight from flops.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        halves_next = halves;
        shreg_next  = shreg;
        cnv_next    = adc_cnv;
        sclk_next   = adc_sclk;
        sample_next = sample;
        strobe_next = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = CONV;
                    cnv_next   = 1'b1;
                    cnt_next   = '0;
                end
            end
            CONV: begin
                if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                    state_next  = SHIFT;
                    cnv_next    = 1'b0;
                    cnt_next    = '0;
                    halves_next = '0;
                    sclk_next   = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(SCLK_DIV - 1)) begin
                    cnt_next = '0;
                    if (halves == HALF_W'(HALVES - 1)) begin
                        state_next  = DONE;
                        sclk_next   = 1'b0;
                        strobe_next = 1'b1;
                        sample_next = shreg;
                    end else begin
                        halves_next = halves + HALF_W'(1);
                        sclk_next   = ~adc_sclk;
                        if (!adc_sclk) begin
                            shreg_next = DATA_WIDTH'({shreg, adc_sdo});
                        end
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a strobe.
    always_ff @(posedge ck100m) begin
        if (!srst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            halves        <= '0;
            shreg         <= '0;
            adc_cnv       <= 1'b0;
            adc_sclk      <= 1'b0;
            sample        <= '0;
            sample_enable <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            halves        <= halves_next;
            shreg         <= shreg_next;
            adc_cnv       <= cnv_next;
            adc_sclk      <= sclk_next;
            sample        <= sample_next;
            sample_enable <= strobe_next;
            busy          <= (state_next != IDLE);
        end
    end

    // Sticky overrun: a tick that lands on a busy sequencer is dropped and
    // flagged; a set in the same cycle as a clear wins.
    always_ff @(posedge ck100m) begin
        if (!srst_n) begin
            overrun <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler: drives a default instance and a short-period
// instance, models the ADC serial output, and compares every cycle against a
// frame-age reference model derived from the timing rules.
module tb_adc_spi_sampler;

    localparam int DW   = 16;
    localparam int CONV = 70;
    localparam int SD   = 4;
    localparam int LAT  = CONV + 32 * SD + 1;

    logic          ck100m = 1'b0;
    logic          srst_n;
    logic          run_a;
    logic          run_b;
    logic          overrun_clr;
    logic          adc_sdo;
    logic          a_cnv, a_sclk, a_en, a_busy, a_over;
    logic [DW-1:0] a_sample;
    logic          b_cnv, b_sclk, b_en, b_busy, b_over;
    logic [DW-1:0] b_sample;

    always #5 ck100m = ~ck100m;

    adc_spi_sampler #(.DATA_WIDTH(DW), .SAMPLE_DIV(1000), .CONV_CYCLES(CONV), .SCLK_DIV(SD)) dut_a (
        .ck100m(ck100m), .srst_n(srst_n), .run(run_a), .overrun_clr(overrun_clr),
        .adc_sdo(adc_sdo), .adc_cnv(a_cnv), .adc_sclk(a_sclk), .sample(a_sample),
        .sample_enable(a_en), .busy(a_busy), .overrun(a_over)
    );

    adc_spi_sampler #(.DATA_WIDTH(DW), .SAMPLE_DIV(150), .CONV_CYCLES(CONV), .SCLK_DIV(SD)) dut_b (
        .ck100m(ck100m), .srst_n(srst_n), .run(run_b), .overrun_clr(overrun_clr),
        .adc_sdo(adc_sdo), .adc_cnv(b_cnv), .adc_sclk(b_sclk), .sample(b_sample),
        .sample_enable(b_en), .busy(b_busy), .overrun(b_over)
    );

    int checks = 0;
    int errors = 0;

    // Which instance is being exercised and checked.
    int sel = 0;
    int cyc = 0;

    // Reference model: frame age counts cycles since the tick (0 = idle).
    int            m_sdiv = 1000;
    int            m_pcnt = 0;
    int            m_age  = 0;
    logic          m_over = 1'b0;
    logic [DW-1:0] m_sample = '0;
    logic [DW-1:0] m_word = '0;
    int            mdl_idx = 0;

    // ADC behavioural model and word source shared by ADC and reference.
    logic [DW-1:0] words[$];
    int            adc_idx = 0;
    int            adc_bit = -1;
    logic [DW-1:0] adc_word = '0;
    logic          prev_cnv = 1'b0;
    logic          prev_sclk = 1'b0;

    // Observation logs.
    int            cnt_cnv = 0;
    int            cnt_rise = 0;
    int            strobe_times[$];
    logic [DW-1:0] strobe_vals[$];
    int            cnv_rises[$];
    logic [DW-1:0] expect_words[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] wordAt(input int idx);
        if (idx < words.size()) return words[idx];
        return DW'(idx * 40503 + 7);
    endfunction

    task automatic queueWord(input logic [DW-1:0] w);
        while (words.size() < mdl_idx) words.push_back(wordAt(words.size()));
        words.push_back(w);
    endtask

    task automatic clearLogs();
        cnt_cnv = 0;
        cnt_rise = 0;
        strobe_times.delete();
        strobe_vals.delete();
        cnv_rises.delete();
        expect_words.delete();
    endtask

    task automatic modelEdge(input bit rst, input bit r, input bit clr);
        bit tk;
        int age_before;
        if (rst) begin
            m_pcnt   = 0;
            m_age    = 0;
            m_over   = 1'b0;
            m_sample = '0;
        end else begin
            tk         = r && (m_pcnt == 0);
            age_before = m_age;
            m_pcnt     = r ? (m_pcnt + 1) % m_sdiv : 0;
            if (age_before != 0) begin
                m_age = (age_before == LAT) ? 0 : age_before + 1;
            end else if (tk) begin
                m_age  = 1;
                m_word = wordAt(mdl_idx);
                mdl_idx++;
            end
            if (tk && age_before != 0) m_over = 1'b1;
            else if (clr) m_over = 1'b0;
            if (m_age == LAT) m_sample = m_word;
        end
    endtask

    task automatic compareAll();
        logic          o_cnv, o_sclk, o_en, o_busy, o_over;
        logic [DW-1:0] o_sample;
        int            k;
        logic          e_sclk;
        if (sel == 0) begin
            o_cnv = a_cnv; o_sclk = a_sclk; o_en = a_en;
            o_busy = a_busy; o_over = a_over; o_sample = a_sample;
        end else begin
            o_cnv = b_cnv; o_sclk = b_sclk; o_en = b_en;
            o_busy = b_busy; o_over = b_over; o_sample = b_sample;
        end
        k = m_age - CONV - 1;
        e_sclk = (m_age != 0) && (k >= 0) && (k < 32 * SD) && (((k / SD) % 2) == 1);
        checkOutput("adc_cnv", 32'(o_cnv), 32'((m_age >= 1) && (m_age <= CONV)));
        checkOutput("adc_sclk", 32'(o_sclk), 32'(e_sclk));
        checkOutput("sample_enable", 32'(o_en), 32'(m_age == LAT));
        checkOutput("busy", 32'(o_busy), 32'(m_age != 0));
        checkOutput("overrun", 32'(o_over), 32'(m_over));
        checkOutput("sample", 32'(o_sample), 32'(m_sample));

        if (o_cnv && !prev_cnv) cnv_rises.push_back(cyc);
        if (o_cnv) cnt_cnv++;
        if (o_sclk && !prev_sclk) cnt_rise++;
        if (o_en) begin
            strobe_times.push_back(cyc);
            strobe_vals.push_back(o_sample);
        end

        // ADC presents the MSB once conversion starts and moves to the next
        // bit after each SCLK falling edge.
        if (o_cnv && !prev_cnv) begin
            adc_word = wordAt(adc_idx);
            adc_idx++;
            adc_bit = DW - 1;
        end else if (!o_sclk && prev_sclk) begin
            adc_bit--;
        end
        adc_sdo   = (adc_bit >= 0) ? adc_word[adc_bit] : 1'b0;
        prev_cnv  = o_cnv;
        prev_sclk = o_sclk;
    endtask

    task automatic applyStimulus(input bit rst, input bit r, input bit clr);
        srst_n = !rst;
        if (sel == 0) run_a = r;
        else run_b = r;
        overrun_clr = clr;
        @(posedge ck100m);
        modelEdge(rst, r, clr);
        cyc++;
        @(negedge ck100m);
        compareAll();
    endtask

    initial begin
        logic [DW-1:0] w;
        srst_n = 1'b0;
        run_a = 1'b0;
        run_b = 1'b0;
        overrun_clr = 1'b0;
        adc_sdo = 1'b0;

        // Reset held with run high, then release: conversion starts at once.
        $display("[TB] reset and first tick");
        queueWord(DW'($urandom));
        repeat (100) applyStimulus(1, 1, 0);
        clearLogs();
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_cnv_after_release", 32'(cnv_rises.size()), 32'(1));
        repeat (260) applyStimulus(0, 0, 0);

        // Single frame returning 0xA5C3.
        $display("[TB] single frame");
        clearLogs();
        queueWord(16'hA5C3);
        applyStimulus(0, 1, 0);
        repeat (260) applyStimulus(0, 0, 0);
        checkOutput("t2_cnv_cycles", 32'(cnt_cnv), 32'(CONV));
        checkOutput("t2_sclk_rises", 32'(cnt_rise), 32'(DW));
        checkOutput("t2_strobes", 32'(strobe_vals.size()), 32'(1));
        if (strobe_vals.size() == 1 && cnv_rises.size() == 1) begin
            checkOutput("t2_value", 32'(strobe_vals[0]), 32'h0000_A5C3);
            checkOutput("t2_latency", 32'(strobe_times[0] - (cnv_rises[0] - 1)), 32'(LAT));
        end

        // Continuous run with edge-case words.
        $display("[TB] continuous run");
        clearLogs();
        expect_words = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE};
        foreach (expect_words[i]) queueWord(expect_words[i]);
        repeat (3999) applyStimulus(0, 1, 0);
        repeat (250) applyStimulus(0, 0, 0);
        checkOutput("t3_strobes", 32'(strobe_vals.size()), 32'(4));
        for (int i = 0; i < 4 && i < strobe_vals.size(); i++) begin
            checkOutput("t3_value", 32'(strobe_vals[i]), 32'(expect_words[i]));
            if (i > 0) checkOutput("t3_spacing", 32'(strobe_times[i] - strobe_times[i-1]), 32'(1000));
        end

        // Run dropped during SHIFT of the second frame.
        $display("[TB] run dropped mid-frame");
        clearLogs();
        expect_words.delete();
        for (int i = 0; i < 2; i++) begin
            w = DW'($urandom);
            expect_words.push_back(w);
            queueWord(w);
        end
        repeat (1100) applyStimulus(0, 1, 0);
        repeat (300) applyStimulus(0, 0, 0);
        checkOutput("t4_strobes", 32'(strobe_vals.size()), 32'(2));
        checkOutput("t4_cnv_count", 32'(cnv_rises.size()), 32'(2));
        for (int i = 0; i < 2 && i < strobe_vals.size(); i++)
            checkOutput("t4_value", 32'(strobe_vals[i]), 32'(expect_words[i]));

        // One-cycle reset in the middle of SHIFT aborts the frame.
        $display("[TB] reset mid-shift");
        applyStimulus(1, 0, 0);
        clearLogs();
        queueWord(DW'($urandom));
        applyStimulus(0, 1, 0);
        repeat (150) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t5_sclk_after_rst", 32'(a_sclk), 32'(0));
        checkOutput("t5_busy_after_rst", 32'(a_busy), 32'(0));
        repeat (250) applyStimulus(0, 0, 0);
        checkOutput("t5_strobes", 32'(strobe_vals.size()), 32'(0));
        checkOutput("t5_sample", 32'(a_sample), 32'(0));

        // Short-period instance: every other tick overruns.
        $display("[TB] overrun instance");
        sel = 1;
        m_sdiv = 150;
        run_a = 1'b0;
        repeat (2) applyStimulus(1, 0, 0);
        clearLogs();
        for (int i = 0; i < 700; i++) applyStimulus(0, 1, (i == 320) || (i == 450));
        checkOutput("t6_strobes", 32'(strobe_times.size()), 32'(2));
        if (strobe_times.size() == 2)
            checkOutput("t6_spacing", 32'(strobe_times[1] - strobe_times[0]), 32'(300));

        // Randomized traffic on the short-period instance.
        $display("[TB] random traffic");
        repeat (40) queueWord(DW'($urandom));
        repeat (2000) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
Sample source for the median filter chain: paces conversions of an external 16-bit SPI ADC (CNV/SCLK/SDO style) at a fixed sample rate on ck100m. It shifts each result in MSB first and presents it as a one-cycle strobed word. sample/sample_enable connect directly to the filter's in/enable, forming the transmitter end of that sample-strobe interface.

Parameters:
DATA_WIDTH, 16, ADC word width and number of SCLK pulses per frame
SAMPLE_DIV, 1000, ck100m cycles between conversion starts (100 kHz)
CONV_CYCLES, 70, ck100m cycles adc_cnv is held high (ADC conversion time)
SCLK_DIV, 4, ck100m cycles per SCLK half-period (12.5 MHz SCLK)

Ports:
ck100m  input  1  100 MHz system clock; all logic on its rising edge
srst_n  input  1  reset, synchronous, active-low
run  input  1  1 = periodic conversions enabled
overrun_clr  input  1  one-cycle pulse; clears overrun
adc_sdo  input  1  ADC serial data; changes after SCLK falling edge
adc_cnv  output  1  conversion start, high during CONV
adc_sclk  output  1  SPI clock, idle low
sample  output  DATA_WIDTH  last completed ADC word, held between strobes
sample_enable  output  1  one-cycle strobe; sample valid in the same cycle
busy  output  1  high in any state other than IDLE
overrun  output  1  sticky; a tick arrived while a frame was in progress

Behaviour:
- Reset (srst_n=0 at a clock edge): all outputs 0, period counter 0, FSM=IDLE, shift register 0. Reset takes priority over all other conditions and may abort a frame in any state; no strobe is produced for an aborted frame.
- Period counter pcnt (0..SAMPLE_DIV-1):
  - Increments and wraps while run=1.
  - Forced to 0 while run=0.
  - tick = run && pcnt==0. The first tick occurs on the first cycle run is seen high.
- FSM: IDLE -> CONV -> SHIFT -> DONE -> IDLE. Timing is relative to a tick in cycle 0.
  - IDLE: on tick go to CONV. adc_cnv=1 from cycle 1.
  - CONV: adc_cnv=1 for exactly CONV_CYCLES cycles (cycles 1..CONV_CYCLES). Then adc_cnv=0 and go to SHIFT.
  - SHIFT:
    - adc_sclk starts low and toggles every SCLK_DIV cycles, giving DATA_WIDTH full periods (32*SCLK_DIV cycles for 16 bits).
    - On each cycle where adc_sclk is driven 0->1, adc_sdo is shifted into the LSB of the shift register.
    - The first bit captured is the MSB.
    - After the final high half-period, adc_sclk returns low and the FSM goes to DONE.
  - DONE (one cycle): sample <= shift register, sample_enable=1, then IDLE.
  - Latency from tick to strobe = CONV_CYCLES + 32*SCLK_DIV + 1 = 199 cycles with defaults.
- run deasserted mid-frame: the frame completes and strobes normally; no new tick follows.
- Overrun:
  - A tick arriving when FSM != IDLE is ignored (no frame started) and sets overrun=1.
  - overrun is cleared only by overrun_clr or reset.
  - Simultaneous set and overrun_clr: set wins.
- sample_enable is never high for two consecutive cycles. sample changes only in a strobe cycle.
- busy = (FSM != IDLE). It is registered with the state.
- Parameter rule: SAMPLE_DIV >= CONV_CYCLES + 32*SCLK_DIV + 2 guarantees no overrun. Smaller values are legal and exercise the overrun path.

Test Plan:
1. srst_n=0 for 100 cycles with run=1 -> all outputs 0 and no SCLK/CNV activity; after release with run=1, adc_cnv rises 1 cycle later.
2. ADC model returns 0xA5C3, single frame (run pulsed then held low) -> adc_cnv high exactly 70 cycles, exactly 16 SCLK rising edges of period 8 cycles, sample=0xA5C3 with sample_enable high 199 cycles after tick, one pulse only.
3. Continuous run, ADC returns 0x0000, 0xFFFF, 0x8001, 0x7FFE -> strobes exactly 1000 cycles apart with those values in order; overrun stays 0; the chained median filter logs each out.
4. Drop run during SHIFT of the 2nd frame -> 2nd frame still strobes its value; no CNV afterwards; busy falls after the DONE cycle.
5. Assert srst_n=0 for 1 cycle mid-SHIFT -> next cycle adc_sclk=0, busy=0, no strobe for that frame; sample keeps reset value 0.
6. Instance with SAMPLE_DIV=150, run=1 -> the tick at cycle 150 is skipped and overrun=1; strobes every 300 cycles; overrun_clr pulse clears overrun, and it is re-set at the next skipped tick.
